// File: rtl/payment_ctrl.sv
// Payment controller for a vending machine: collects coins against a latched price,
// requests a vend, returns change one unit per cycle and reports the transaction result.
module payment_ctrl #(
   parameter int unsigned W       = 8,
   parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] price,
   input  logic         coin_valid,
   input  logic [1:0]   coin_val,
   input  logic         cancel,
   input  logic         vend_ack,
   output logic [W-1:0] paid,
   output logic [W-1:0] change_left,
   output logic         change_pulse,
   output logic         coin_reject,
   output logic         vend_req,
   output logic         finish,
   output logic         success,
   output logic [2:0]   state
);

   typedef enum logic [2:0] {
      StIdle    = 3'b000,
      StCollect = 3'b001,
      StVend    = 3'b010,
      StChange  = 3'b011,
      StDone    = 3'b100
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] price_q, price_d;
   logic [W-1:0] paid_q, paid_d;
   logic [W-1:0] change_q, change_d;
   logic [31:0]  timer_q, timer_d;
   logic         vend_req_q, vend_req_d;
   logic         success_q, success_d;

   logic [4:0]   coin_amt;
   logic [W:0]   paid_sum;
   logic [W-1:0] paid_sat;

   // Coin code to face value.
   always_comb begin
      coin_amt = 5'd1;
      case (coin_val)
         2'b00:   coin_amt = 5'd1;
         2'b01:   coin_amt = 5'd5;
         2'b10:   coin_amt = 5'd10;
         default: coin_amt = 5'd20;
      endcase
   end

   // Saturating add of the presented coin to the running total.
   always_comb begin
      paid_sum = {1'b0, paid_q} + {1'b0, W'(coin_amt)};
      paid_sat = paid_sum[W] ? {W{1'b1}} : paid_sum[W-1:0];
   end

   // Next-state and next-value logic for the transaction FSM.
   always_comb begin
      state_d    = state_q;
      price_d    = price_q;
      paid_d     = paid_q;
      change_d   = change_q;
      timer_d    = timer_q;
      vend_req_d = vend_req_q;
      success_d  = success_q;
      case (state_q)
         StIdle: begin
            if (start && (price != '0)) begin
               price_d = price;
               paid_d  = '0;
               timer_d = '0;
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (coin_valid) begin
               paid_d  = paid_sat;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
            // Exit tests use the registered total; a same-cycle coin still lands in paid_d.
            if (cancel) begin
               change_d  = paid_d;
               success_d = 1'b0;
               state_d   = StChange;
            end else if (paid_q >= price_q) begin
               vend_req_d = 1'b1;
               state_d    = StVend;
            end else if (timer_q == (TIMEOUT - 32'd1)) begin
               change_d  = paid_d;
               success_d = 1'b0;
               state_d   = StChange;
            end
         end
         StVend: begin
            if (vend_ack) begin
               change_d   = paid_q - price_q;
               success_d  = 1'b1;
               vend_req_d = 1'b0;
               state_d    = StChange;
            end
         end
         StChange: begin
            if (change_q != '0) begin
               change_d = change_q - W'(1);
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            paid_d  = '0;
            state_d = StIdle;
         end
         default: begin
            vend_req_d = 1'b0;
            state_d    = StIdle;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction without refund.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         price_q    <= '0;
         paid_q     <= '0;
         change_q   <= '0;
         timer_q    <= '0;
         vend_req_q <= 1'b0;
         success_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         price_q    <= price_d;
         paid_q     <= paid_d;
         change_q   <= change_d;
         timer_q    <= timer_d;
         vend_req_q <= vend_req_d;
         success_q  <= success_d;
      end
   end

   // Pulses decode registered state only (plus the coin strobe), so they change just after edges.
   always_comb begin
      change_pulse = (state_q == StChange) && (change_q != '0);
      coin_reject  = coin_valid && (state_q != StCollect) && !rst;
      finish       = (state_q == StDone);
   end

   assign paid        = paid_q;
   assign change_left = change_q;
   assign vend_req    = vend_req_q;
   assign success     = success_q;
   assign state       = state_q;

endmodule

// File: tb/tb_payment_ctrl.sv
// Directed self-checking bench for payment_ctrl (W=8, TIMEOUT=16).
module tb_payment_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] price;
   logic         coin_valid;
   logic [1:0]   coin_val;
   logic         cancel;
   logic         vend_ack;
   logic [W-1:0] paid;
   logic [W-1:0] change_left;
   logic         change_pulse;
   logic         coin_reject;
   logic         vend_req;
   logic         finish;
   logic         success;
   logic [2:0]   state;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses;
   int bad;
   bit vend_seen;

   payment_ctrl #(
      .W       (W),
      .TIMEOUT (32'd16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .price        (price),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .cancel       (cancel),
      .vend_ack     (vend_ack),
      .paid         (paid),
      .change_left  (change_left),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .vend_req     (vend_req),
      .finish       (finish),
      .success      (success),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Run out the CHANGE phase (bounded), counting refund pulses.
   task automatic drain(output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (state != 3'b011) break;
         if (change_pulse) cnt++;
         if (vend_req) vend_seen = 1'b1;
         cyc();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; price = '0; coin_valid = 1'b0; coin_val = 2'b00;
      cancel = 1'b0; vend_ack = 1'b0; vend_seen = 1'b0;
      repeat (2) cyc();
      check("rst_state", 32'(state), 32'd0);
      check("rst_paid", 32'(paid), 32'd0);
      check("rst_change", 32'(change_left), 32'd0);
      check("rst_vend_req", 32'(vend_req), 32'd0);
      check("rst_success", 32'(success), 32'd0);
      check("rst_finish", 32'(finish), 32'd0);
      rst = 1'b0;
      cyc();

      // Zero-price start ignored; coin in IDLE rejected and not counted.
      start = 1'b1; price = 8'd0;
      cyc();
      start = 1'b0;
      check("zero_price_idle", 32'(state), 32'd0);
      coin_valid = 1'b1; coin_val = 2'b11;
      #1;
      check("idle_reject", 32'(coin_reject), 32'd1);
      cyc();
      coin_valid = 1'b0;
      check("idle_paid", 32'(paid), 32'd0);

      // Overpay: price 15, coins 10+10.
      start = 1'b1; price = 8'd15;
      cyc();
      start = 1'b0;
      check("op_collect", 32'(state), 32'd1);
      coin_valid = 1'b1; coin_val = 2'b10;
      #1;
      check("op_no_reject", 32'(coin_reject), 32'd0);
      cyc();
      check("op_paid10", 32'(paid), 32'd10);
      cyc();
      coin_valid = 1'b0;
      check("op_paid20", 32'(paid), 32'd20);
      check("op_still_collect", 32'(state), 32'd1);
      cyc();
      check("op_vend", 32'(state), 32'd2);
      check("op_vend_req1", 32'(vend_req), 32'd1);
      cyc();
      check("op_vend_req2", 32'(vend_req), 32'd1);
      cyc();
      check("op_vend_req3", 32'(vend_req), 32'd1);
      vend_ack = 1'b1;
      cyc();
      vend_ack = 1'b0;
      check("op_change", 32'(state), 32'd3);
      check("op_change_left", 32'(change_left), 32'd5);
      check("op_vend_req_off", 32'(vend_req), 32'd0);
      check("op_success", 32'(success), 32'd1);
      drain(pulses);
      check("op_pulses", 32'(pulses), 32'd5);
      check("op_done", 32'(state), 32'd4);
      check("op_finish", 32'(finish), 32'd1);
      cyc();
      check("op_idle", 32'(state), 32'd0);
      check("op_finish_once", 32'(finish), 32'd0);
      check("op_paid_clr", 32'(paid), 32'd0);
      check("op_success_hold", 32'(success), 32'd1);

      // Exact pay: price 5, coin 5.
      start = 1'b1; price = 8'd5;
      cyc();
      start = 1'b0;
      coin_valid = 1'b1; coin_val = 2'b01;
      cyc();
      coin_valid = 1'b0;
      check("ex_paid", 32'(paid), 32'd5);
      check("ex_latency", 32'(state), 32'd1);
      cyc();
      check("ex_vend", 32'(state), 32'd2);
      vend_ack = 1'b1;
      cyc();
      vend_ack = 1'b0;
      check("ex_change", 32'(state), 32'd3);
      check("ex_change_left", 32'(change_left), 32'd0);
      check("ex_no_pulse", 32'(change_pulse), 32'd0);
      cyc();
      check("ex_done", 32'(state), 32'd4);
      check("ex_finish", 32'(finish), 32'd1);
      check("ex_success", 32'(success), 32'd1);
      cyc();
      check("ex_idle", 32'(state), 32'd0);

      // Cancel with a same-cycle coin: price 20, coin 5.
      start = 1'b1; price = 8'd20;
      cyc();
      start = 1'b0;
      coin_valid = 1'b1; coin_val = 2'b01; cancel = 1'b1;
      cyc();
      coin_valid = 1'b0; cancel = 1'b0;
      check("cn_change", 32'(state), 32'd3);
      check("cn_change_left", 32'(change_left), 32'd5);
      check("cn_success", 32'(success), 32'd0);
      vend_seen = 1'b0;
      drain(pulses);
      check("cn_pulses", 32'(pulses), 32'd5);
      check("cn_no_vend", 32'(vend_seen), 32'd0);
      check("cn_finish", 32'(finish), 32'd1);
      cyc();

      // Timeout: price 10, single coin 1, 16 idle cycles.
      start = 1'b1; price = 8'd10;
      cyc();
      start = 1'b0;
      coin_valid = 1'b1; coin_val = 2'b00;
      cyc();
      coin_valid = 1'b0;
      check("to_paid", 32'(paid), 32'd1);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (state != 3'b001) bad++;
         cyc();
      end
      check("to_wait16", 32'(bad), 32'd0);
      check("to_change", 32'(state), 32'd3);
      check("to_change_left", 32'(change_left), 32'd1);
      check("to_success", 32'(success), 32'd0);
      drain(pulses);
      check("to_pulses", 32'(pulses), 32'd1);
      check("to_finish", 32'(finish), 32'd1);
      cyc();

      // Saturation: price 255, 13 coins of 20; coin in VEND rejected.
      start = 1'b1; price = 8'd255;
      cyc();
      start = 1'b0;
      coin_valid = 1'b1; coin_val = 2'b11;
      repeat (12) cyc();
      check("sat_paid240", 32'(paid), 32'd240);
      cyc();
      coin_valid = 1'b0;
      check("sat_paid255", 32'(paid), 32'd255);
      check("sat_collect", 32'(state), 32'd1);
      cyc();
      check("sat_vend", 32'(state), 32'd2);
      coin_valid = 1'b1; coin_val = 2'b11;
      #1;
      check("sat_reject", 32'(coin_reject), 32'd1);
      cyc();
      coin_valid = 1'b0;
      check("sat_paid_hold", 32'(paid), 32'd255);
      check("sat_still_vend", 32'(state), 32'd2);
      vend_ack = 1'b1;
      cyc();
      vend_ack = 1'b0;
      check("sat_change0", 32'(change_left), 32'd0);
      check("sat_no_pulse", 32'(change_pulse), 32'd0);
      cyc();
      check("sat_finish", 32'(finish), 32'd1);
      cyc();

      // Reset during CHANGE with 3 units outstanding.
      start = 1'b1; price = 8'd2;
      cyc();
      start = 1'b0;
      coin_valid = 1'b1; coin_val = 2'b01;
      cyc();
      coin_valid = 1'b0;
      cyc();
      check("rc_vend", 32'(state), 32'd2);
      vend_ack = 1'b1;
      cyc();
      vend_ack = 1'b0;
      check("rc_change_left", 32'(change_left), 32'd3);
      check("rc_pulse", 32'(change_pulse), 32'd1);
      rst = 1'b1;
      #1;
      check("rc_state", 32'(state), 32'd0);
      check("rc_change_clr", 32'(change_left), 32'd0);
      check("rc_paid_clr", 32'(paid), 32'd0);
      check("rc_pulse_clr", 32'(change_pulse), 32'd0);
      check("rc_success_clr", 32'(success), 32'd0);
      check("rc_vend_req_clr", 32'(vend_req), 32'd0);
      cyc();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (finish || change_pulse || (state != 3'b000)) bad++;
         cyc();
      end
      check("rc_quiet", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
